// File: rtl/usb_tx_line_driver_pkg.sv
// usb_tx_line_driver_pkg: line codes, tx FSM states and framing constants shared by the USB TX/RX line logic
package usb_line_pkg;
  localparam logic [1:0] LS_J = 2'b01;
  localparam logic [1:0] LS_K = 2'b10;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int STUFF_LIMIT = 6;
  typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_EOP_SE0, TX_EOP_J} tx_state_e;
  function automatic logic [1:0] line_code(input logic level);
    return level ? LS_J : LS_K;
  endfunction
endpackage

// File: rtl/usb_tx_line_driver_if.sv
// usb_tx_line_driver_if: UTMI-style byte handshake plus the driven line signals
interface usb_tx_line_driver_if;
  logic       TX_VALID;
  logic [7:0] DATA_IN;
  logic       TX_READY;
  logic       TX_en;
  logic       TX_DP;
  logic       TX_DM;
  modport master (output TX_VALID, DATA_IN, input TX_READY, TX_en, TX_DP, TX_DM);
  modport slave (input TX_VALID, DATA_IN, output TX_READY, TX_en, TX_DP, TX_DM);
endinterface

// File: rtl/usb_tx_line_driver_nrzi_stuff.sv
// usb_tx_nrzi_stuff: NRZI line level (1 = J) with bit-stuff detection on the pre-NRZI bit stream
module usb_tx_nrzi_stuff
  import usb_line_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic i_tick,
  input  logic i_bit,
  input  logic i_start,
  output logic o_stuff_now,
  output logic o_level
);
  logic [2:0] r_ones;
  logic       r_level;
  logic       w_zero;
  assign o_stuff_now = r_ones == 3'(STUFF_LIMIT);
  assign o_level = r_level;
  // a stuffed bit behaves exactly like a data 0
  assign w_zero = o_stuff_now || !i_bit;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ones <= '0;
      r_level <= 1'b1;
    end else if (i_start) begin
      r_level <= i_bit;
      r_ones <= {2'b00, i_bit};
    end else if (i_tick) begin
      r_level <= r_level ^ w_zero;
      r_ones <= w_zero ? '0 : r_ones + 3'd1;
    end
  end
endmodule

// File: rtl/usb_tx_line_driver.sv
// usb_tx_line_driver: FS transmit path framing UTMI bytes as SYNC + stuffed NRZI data + EOP
module usb_tx_line_driver
  import usb_line_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input logic CLK,
  input logic RST,
  usb_tx_line_driver_if.slave tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_e     r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [6:0]    r_shift;
  logic [2:0]    r_idx;
  logic          r_ready;
  logic          w_tick, w_start, w_last, w_nrzi_tick, w_bit, w_stuff_now, w_level;
  assign w_tick = r_state != TX_IDLE && r_bit_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_start = r_state == TX_IDLE && tx.TX_VALID;
  assign w_last = r_idx == 3'd7;
  assign w_nrzi_tick = w_tick && (r_state == TX_SYNC || r_state == TX_DATA);
  // r_shift holds the bits still to go, so bit 0 is always the next one out
  assign w_bit = w_start ? SYNC_PATTERN[0] : w_last ? tx.DATA_IN[0] : r_shift[0];
  usb_tx_nrzi_stuff u_nrzi (
    .CLK         (CLK),
    .RST         (RST),
    .i_tick      (w_nrzi_tick),
    .i_bit       (w_bit),
    .i_start     (w_start),
    .o_stuff_now (w_stuff_now),
    .o_level     (w_level)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= TX_IDLE;
      r_bit_cnt <= '0;
      r_shift <= '0;
      r_idx <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_bit_cnt <= (r_state == TX_IDLE || w_tick) ? '0 : r_bit_cnt + CW'(1);
      if (w_start) begin
        r_state <= TX_SYNC;
        r_shift <= SYNC_PATTERN[7:1];
        r_idx <= '0;
      end else if (w_tick) begin
        if (r_state == TX_EOP_J) begin
          r_state <= TX_IDLE;
        end else if (r_state == TX_EOP_SE0) begin
          r_idx <= r_idx + 3'd1;
          if (r_idx[0]) r_state <= TX_EOP_J;
        end else if (!w_stuff_now) begin
          if (!w_last) begin
            r_shift <= r_shift >> 1;
            r_idx <= r_idx + 3'd1;
          end else if (tx.TX_VALID) begin
            r_state <= TX_DATA;
            r_shift <= tx.DATA_IN[7:1];
            r_idx <= '0;
            r_ready <= 1'b1;
          end else begin
            r_state <= TX_EOP_SE0;
            r_idx <= '0;
          end
        end
      end
    end
  end
  assign tx.TX_READY = r_ready;
  assign tx.TX_en = r_state != TX_IDLE;
  assign {tx.TX_DM, tx.TX_DP} = r_state == TX_EOP_SE0 ? LS_SE0 :
                                (r_state == TX_IDLE || r_state == TX_EOP_J) ? LS_J :
                                line_code(w_level);
endmodule

// File: tb/tb_usb_tx_line_driver.sv
// tb_usb_tx_line_driver: random and directed packets against a bit-level line model, checked by a scoreboard monitor
module tb_usb_tx_line_driver;
  localparam int CPB = 4;
  localparam logic [1:0] J = 2'b01;
  localparam logic [1:0] K = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  typedef struct {
    logic [1:0] sym;
    bit         rdy;
    bit         last;
  } exp_t;

  logic CLK = 0;
  logic RST = 1;
  usb_tx_line_driver_if bus();
  usb_tx_line_driver #(.CLKS_PER_BIT(CPB)) dut (.CLK(CLK), .RST(RST), .tx(bus));
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit in_pkt = 0;
  bit flush = 1;
  int cyc = 0;
  logic [7:0] pkt[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
  endtask

  task automatic push_sym(input logic [1:0] s, input bit r, input bit l);
    exp_t e;
    e.sym = s;
    e.rdy = r;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // one entry per bit time on the line: SYNC and data bits with NRZI and stuffing, then EOP
  task automatic push_model();
    logic [7:0] stream[$];
    logic [7:0] by;
    int ones = 0;
    bit lvl = 1;
    stream.push_back(8'h80);
    foreach (pkt[i]) stream.push_back(pkt[i]);
    for (int k = 0; k < stream.size(); k++) begin
      by = stream[k];
      for (int i = 0; i < 8; i++) begin
        if (by[i]) ones++;
        else begin
          ones = 0;
          lvl = !lvl;
        end
        push_sym(lvl ? J : K, k > 0 && i == 0, 0);
        if (ones == 6) begin
          ones = 0;
          lvl = !lvl;
          push_sym(lvl ? J : K, 0, 0);
        end
      end
    end
    push_sym(SE0, 0, 0);
    push_sym(SE0, 0, 0);
    push_sym(J, 0, 1);
  endtask

  always @(negedge CLK) begin
    if (flush) begin
      in_pkt = 0;
      exp_q.delete();
    end else begin
      if (!in_pkt) begin
        if (bus.TX_en) begin
          if (exp_q.size() == 0) chk("unexpected_tx_en", 1, 0);
          else begin
            cur = exp_q.pop_front();
            in_pkt = 1;
            cyc = 0;
          end
        end else chk("idle_line", {bus.TX_READY, bus.TX_DM, bus.TX_DP}, {1'b0, J});
      end
      if (in_pkt) begin
        chk("line_cycle", {bus.TX_en, bus.TX_READY, bus.TX_DM, bus.TX_DP},
            {1'b1, cur.rdy && cyc == 0, cur.sym});
        cyc++;
        if (cyc == CPB) begin
          cyc = 0;
          if (cur.last || exp_q.size() == 0) in_pkt = 0;
          else cur = exp_q.pop_front();
        end
      end
    end
  end

  task automatic send(input int drop);
    int t;
    push_model();
    @(negedge CLK);
    bus.TX_VALID = 1;
    bus.DATA_IN = pkt.size() > 0 ? pkt[0] : 8'($urandom);
    for (int k = 0; k < pkt.size(); k++) begin
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (!bus.TX_READY && t < 200);
      chk("ready_wait", t < 200, 1);
      bus.DATA_IN = k + 1 < pkt.size() ? pkt[k + 1] : 8'($urandom);
    end
    repeat (drop) @(negedge CLK);
    bus.TX_VALID = 0;
    t = 0;
    while ((exp_q.size() != 0 || in_pkt) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk("pkt_done", t < 3000, 1);
    repeat ($urandom_range(1, 5)) @(negedge CLK);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0: return 8'hFF;
      1: return 8'hFC;
      2: return 8'h7E;
      3: return 8'h3F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    bus.TX_VALID = 0;
    bus.DATA_IN = 0;
    repeat (3) @(negedge CLK);
    chk("rst_en", bus.TX_en, 0);
    chk("rst_dp", bus.TX_DP, 1);
    chk("rst_dm", bus.TX_DM, 0);
    chk("rst_ready", bus.TX_READY, 0);
    RST = 0;
    flush = 0;
    @(negedge CLK);
    pkt = {8'h00};
    send($urandom_range(1, 8 * CPB - 4));
    pkt = {8'hFF};
    send($urandom_range(1, 8 * CPB - 4));
    pkt = {8'hA5, 8'h3C};
    send($urandom_range(1, 8 * CPB - 4));
    pkt = {8'h5A, 8'hFC};
    send($urandom_range(1, 8 * CPB - 4));
    pkt = {8'($urandom), 8'($urandom)};
    send(3 * CPB);
    pkt = {};
    send($urandom_range(1, 20));
    flush = 1;
    @(negedge CLK);
    bus.TX_VALID = 1;
    bus.DATA_IN = 8'hFF;
    repeat (11 * CPB) @(negedge CLK);
    RST = 1;
    bus.TX_VALID = 0;
    @(negedge CLK);
    chk("midrst_en", bus.TX_en, 0);
    chk("midrst_dp", bus.TX_DP, 1);
    chk("midrst_dm", bus.TX_DM, 0);
    chk("midrst_ready", bus.TX_READY, 0);
    RST = 0;
    repeat (8) begin
      @(negedge CLK);
      chk("no_eop", {bus.TX_en, bus.TX_DM, bus.TX_DP}, {1'b0, J});
    end
    flush = 0;
    pkt = {8'h81};
    send($urandom_range(1, 8 * CPB - 4));
    for (int p = 0; p < 14; p++) begin
      pkt = {};
      for (int b = 0; b < $urandom_range(0, 4); b++) pkt.push_back(pick_byte());
      send(pkt.size() == 0 ? $urandom_range(1, 20) : $urandom_range(1, 8 * CPB - 4));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
